// File: rtl/timing_sequencer.sv
// Triple-redundant phase/bit/syllable timing sequencer with 2-of-3 voting.
// Optional per-channel miscompare flags are enabled with `define TIMING_MISCOMPARE_EN.
module timing_sequencer #(
    parameter int PHASES       = 4,
    parameter int BITS_PER_SYL = 14
) (
    input  logic       SIM_CLK,
    input  logic       SIM_RST,
    input  logic [2:0] ADV,
    input  logic       GO,
    input  logic       HALT,
    input  logic       ERR_CLR,
    output logic       RUN,
    output logic       HALT_ACK,
    output logic [1:0] PHASE,
    output logic [3:0] BIT,
    output logic       SYL,
    output logic       WORD_END,
    output logic [2:0] CH_ERR
);

    localparam logic [1:0] PHASE_LAST = 2'(PHASES - 1);
    localparam logic [3:0] BIT_LAST   = 4'(BITS_PER_SYL - 1);
    localparam logic [6:0] TERMINAL   = {1'b1, BIT_LAST, PHASE_LAST};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOPPING
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [2:0][6:0]  ch_q;
    logic [2:0][6:0]  ch_d;
    logic [6:0]       voted;
    logic [6:0]       voted_inc;
    logic             adv_event;
    logic             counting;
    logic             wrap;
    logic             load_zero;
    logic             halt_done;
    logic             word_end_q;
    logic             halt_ack_q;

    function automatic logic [6:0] majority(input logic [6:0] a,
                                            input logic [6:0] b,
                                            input logic [6:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Word layout is {SYL, BIT, PHASE}; the terminal word rolls over to zero
    // because SYL toggles back from 1 at the same time BIT and PHASE clear.
    function automatic logic [6:0] inc_word(input logic [6:0] w);
        logic       s;
        logic [3:0] b;
        logic [1:0] p;
        {s, b, p} = w;
        if (p == PHASE_LAST) begin
            p = '0;
            if (b == BIT_LAST) begin
                b = '0;
                s = ~s;
            end else begin
                b = b + 4'd1;
            end
        end else begin
            p = p + 2'd1;
        end
        return {s, b, p};
    endfunction

    assign voted     = majority(ch_q[0], ch_q[1], ch_q[2]);
    assign voted_inc = inc_word(voted);
    assign adv_event = (ADV[0] & ADV[1]) | (ADV[0] & ADV[2]) | (ADV[1] & ADV[2]);
    assign counting  = (state_q == ST_RUN) || (state_q == ST_STOPPING);
    assign wrap      = counting && adv_event && (voted == TERMINAL);

    always_comb begin
        state_d   = state_q;
        load_zero = 1'b0;
        halt_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (GO) begin
                    state_d   = ST_RUN;
                    load_zero = 1'b1;
                end
            end
            ST_RUN: begin
                if (HALT && wrap) begin
                    state_d   = ST_IDLE;
                    halt_done = 1'b1;
                end else if (HALT) begin
                    state_d = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                if (wrap) begin
                    state_d   = ST_IDLE;
                    halt_done = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Each advancing channel takes the increment of the vote, so a lagging
    // channel is pulled back into line on its next own advance strobe.
    always_comb begin
        ch_d = ch_q;
        for (int i = 0; i < 3; i++) begin
            if (load_zero) begin
                ch_d[i] = '0;
            end else if (counting && ADV[i]) begin
                ch_d[i] = voted_inc;
            end
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            state_q    <= ST_IDLE;
            ch_q       <= '0;
            word_end_q <= 1'b0;
            halt_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            word_end_q <= wrap;
            halt_ack_q <= halt_done;
        end
    end

`ifdef TIMING_MISCOMPARE_EN
    logic [6:0] voted_d;
    logic [2:0] mis;
    logic [2:0] err_q;

    // Flags reflect the channel words being loaded on this edge.
    always_comb begin
        voted_d = majority(ch_d[0], ch_d[1], ch_d[2]);
        mis     = '0;
        for (int i = 0; i < 3; i++) begin
            mis[i] = (ch_d[i] != voted_d);
        end
    end

    always_ff @(posedge SIM_CLK or negedge SIM_RST) begin
        if (!SIM_RST) begin
            err_q <= '0;
        end else begin
            err_q <= mis | (err_q & ~{3{ERR_CLR}});
        end
    end

    assign CH_ERR = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = ERR_CLR;
    assign CH_ERR         = '0;
`endif

    assign RUN              = counting;
    assign HALT_ACK         = halt_ack_q;
    assign WORD_END         = word_end_q;
    assign {SYL, BIT, PHASE} = voted;

endmodule

// File: doc/timing_sequencer.md
TIMING_SEQUENCER -- requirements
Module: timing_sequencer

Interface
REQ-001 Parameter: PHASES, default 4, phases per bit time (2..4).
REQ-002 Parameter: BITS_PER_SYL, default 14, bit times per syllable (2..16).
REQ-003 Port: SIM_CLK  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port: SIM_RST  input  1  reset, asynchronous, active-low.
REQ-005 Port: ADV  input  3  per-channel advance strobes; ADV[i] drives redundant channel i.
REQ-006 Port: GO  input  1  start request, level-sampled.
REQ-007 Port: HALT  input  1  stop-at-word-boundary request, level-sampled.
REQ-008 Port: ERR_CLR  input  1  clears CH_ERR.
REQ-009 Port: RUN  output  1  high in RUN and STOPPING states.
REQ-010 Port: HALT_ACK  output  1  one-cycle pulse when a halt completes.
REQ-011 Port: PHASE  output  2  voted phase count.
REQ-012 Port: BIT  output  4  voted bit-time count.
REQ-013 Port: SYL  output  1  voted syllable index (0/1).
REQ-014 Port: WORD_END  output  1  one-cycle pulse after the voted count wraps.
REQ-015 Port: CH_ERR  output  3  sticky per-channel miscompare flags.

Function
REQ-016 SHALL hold three channel state words, each {SYL,BIT,PHASE}; voted word = bitwise 2-of-3 majority of the three; PHASE/BIT/SYL outputs = voted word (combinational from registers).
REQ-017 Advance event SHALL be majority(ADV[0],ADV[1],ADV[2]); counting occurs only in RUN or STOPPING.
REQ-018 In RUN/STOPPING, channel i next = ADV[i] ? inc(voted) : own value; a divergent channel resynchronises from the vote on its next advance.
REQ-019 inc(): PHASE+1; at PHASES-1 -> PHASE=0, BIT+1; at BIT=BITS_PER_SYL-1 -> BIT=0, SYL toggles; terminal word {1,BITS_PER_SYL-1,PHASES-1} wraps to all-zero.
REQ-020 Wrap SHALL occur when voted word is terminal and an advance event occurs; WORD_END pulses high exactly the following cycle.
REQ-021 FSM states IDLE, RUN, STOPPING; IDLE --GO--> RUN with all three channels loaded to 0 on that edge; RUN --HALT--> STOPPING; STOPPING --wrap--> IDLE.
REQ-022 RUN with HALT high on the same cycle as a wrap SHALL go directly to IDLE.
REQ-023 HALT_ACK SHALL pulse the cycle after any entry to IDLE from RUN/STOPPING; coincides with WORD_END.
REQ-024 In IDLE, HALT SHALL be ignored; GO and HALT together in IDLE -> RUN.
REQ-025 In STOPPING, deasserting HALT SHALL NOT cancel the stop; GO SHALL be ignored outside IDLE.
REQ-026 In IDLE, channel words SHALL hold; WORD_END SHALL stay low.

Reset
REQ-027 SIM_RST low SHALL immediately force IDLE, all channel words 0, RUN=0, HALT_ACK=0, WORD_END=0, CH_ERR=000, regardless of SIM_CLK.
REQ-028 Reset asserted mid-word SHALL abandon the word without a WORD_END or HALT_ACK pulse; first edge after release sees IDLE.

Configuration
REQ-029 Macro TIMING_MISCOMPARE_EN defined: CH_ERR[i] sets on any edge where channel i word differs from voted word; clears on ERR_CLR; set wins over simultaneous ERR_CLR.
REQ-030 Macro TIMING_MISCOMPARE_EN undefined: no comparison logic; CH_ERR tied 000; ERR_CLR unused.

Verification
REQ-031 Reset, GO=1 one cycle, ADV=111 continuous -> RUN=1 next cycle; PHASE 0,1,2,3,0; BIT increments every 4 cycles; WORD_END pulse 112 advances after GO.
REQ-032 RUN, HALT=1 at BIT=5 SYL=0 -> counting continues; at wrap RUN=0, HALT_ACK and WORD_END both pulse once; outputs hold 0.
REQ-033 RUN, ADV=101 for 3 cycles then 111 -> voted count advances 3; with TIMING_MISCOMPARE_EN CH_ERR=010 sticky; channel 1 realigned after first ADV[1]; ERR_CLR -> 000.
REQ-034 RUN, ADV=100 -> no advance event, voted word unchanged; with TIMING_MISCOMPARE_EN CH_ERR=001 after first edge.
REQ-035 SIM_RST pulsed low between edges at BIT=9 -> outputs 0 immediately, no WORD_END/HALT_ACK; GO restarts from 0.
REQ-036 IDLE, GO=1 and HALT=1 same cycle -> RUN; HALT held -> STOPPING; stop at first wrap, HALT_ACK once.
